mem_write_arbiter: RTL and testbench

- Shares one Avalon-MM 64-bit write master port between NUM_REQ internal requesters.
- The shared port drives the memory-mapped PIO/memory slave, e.g. the 64-bit register sink on the stack-ISA debug/IO path.
- Arbitration is round-robin. Each transfer is captured into output registers and held stable across avm_waitrequest.
- Each requester receives a single-cycle acknowledge on completion.

---
 rtl/mem_write_arbiter.sv | 113 +++++++++++
 tb/tb_mem_write_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM write master between NUM_REQ requesters.
// Each transfer is captured into output registers and held until the slave accepts it.
module mem_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 64,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        avm_write,
    output logic [ADDR_W-1:0]           avm_address,
    output logic [DATA_W-1:0]           avm_writedata,
    input  logic                        avm_waitrequest,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id
);

    // Handshake: a write completes in the cycle where avm_write=1 and
    // avm_waitrequest=0; address/data stay frozen until then, and that same
    // cycle pulses req_ack for the granted requester.
    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, ptr_nxt;
    logic [ID_W-1:0]   gid_nxt;
    logic              write_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    int                scan_idx;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_address[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_writedata[g*DATA_W +: DATA_W];
    end

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && req[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        write_nxt = avm_write;
        addr_nxt  = avm_address;
        data_nxt  = avm_writedata;
        gid_nxt   = grant_id;
        ptr_nxt   = rr_ptr;
        req_ack   = '0;
        case (state)
            S_IDLE: begin
                write_nxt = 1'b0;
                if (win_found) begin
                    addr_nxt  = addr_arr[win_id];
                    data_nxt  = data_arr[win_id];
                    gid_nxt   = win_id;
                    write_nxt = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    // Gated by reset so a reset cycle never acknowledges a write.
                    req_ack[grant_id] = !reset;
                    write_nxt = 1'b0;
                    ptr_nxt   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            rr_ptr        <= '0;
            grant_id      <= '0;
        end else begin
            state         <= state_nxt;
            avm_write     <= write_nxt;
            avm_address   <= addr_nxt;
            avm_writedata <= data_nxt;
            rr_ptr        <= ptr_nxt;
            grant_id      <= gid_nxt;
        end
    end

    assign busy = (state == S_WRITE);

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed testbench for mem_write_arbiter: single writes, stalls, round-robin order,
// pointer wrap, data isolation during a stall, and reset in the middle of a write.
module tb_mem_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 64;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      avm_write;
    logic [ADDR_W-1:0]         avm_address;
    logic [DATA_W-1:0]         avm_writedata;
    logic                      avm_waitrequest;
    logic                      busy;
    logic [1:0]                grant_id;

    logic [ADDR_W-1:0] addr_v [NUM_REQ];
    logic [DATA_W-1:0] data_v [NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;

    mem_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .req_ack         (req_ack),
        .avm_write       (avm_write),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_address   = '0;
        req_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_address[i*ADDR_W +: ADDR_W]   = addr_v[i];
            req_writedata[i*DATA_W +: DATA_W] = data_v[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Caller is in an IDLE cycle with req already set; expects a zero-stall grant.
    task automatic do_grant(input int exp_id, input string tag);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << exp_id;
        tick();
        #1;
        check({tag, "_write"}, 64'(avm_write), 64'd1);
        check({tag, "_gid"},   64'(grant_id), 64'(exp_id));
        check({tag, "_ack"},   64'(req_ack), 64'(exp_ack));
        check({tag, "_addr"},  64'(avm_address), 64'(addr_v[exp_id]));
        check({tag, "_data"},  avm_writedata, data_v[exp_id]);
        tick();
        #1;
        check({tag, "_idle_write"}, 64'(avm_write), 64'd0);
        check({tag, "_idle_ack"},   64'(req_ack), 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        avm_waitrequest = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_v[i] = ADDR_W'(11'h010 + i);
            data_v[i] = 64'h1000_0000_0000_0000 + 64'(i);
        end
        apply_reset();
        #1;
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr",  64'(avm_address), 64'd0);
        check("rst_data",  avm_writedata, 64'd0);
        check("rst_gid",   64'(grant_id), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ack",   64'(req_ack), 64'd0);

        // Single requester, no stall
        addr_v[2] = 11'h155;
        data_v[2] = 64'hDEAD_BEEF_0123_4567;
        req = 4'b0100;
        #1;
        check("single_idle_ack", 64'(req_ack), 64'd0);
        tick();
        #1;
        check("single_write", 64'(avm_write), 64'd1);
        check("single_addr",  64'(avm_address), 64'h155);
        check("single_data",  avm_writedata, 64'hDEAD_BEEF_0123_4567);
        check("single_gid",   64'(grant_id), 64'd2);
        check("single_busy",  64'(busy), 64'd1);
        check("single_ack",   64'(req_ack), 64'b0100);
        tick();
        req = '0;
        #1;
        check("single_after_write", 64'(avm_write), 64'd0);
        check("single_after_busy",  64'(busy), 64'd0);
        check("single_after_ack",   64'(req_ack), 64'd0);

        // Five stall cycles, acceptance in the sixth WRITE cycle
        req = 4'b0100;
        avm_waitrequest = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_write", 64'(avm_write), 64'd1);
            check("stall_addr",  64'(avm_address), 64'h155);
            check("stall_data",  avm_writedata, 64'hDEAD_BEEF_0123_4567);
            check("stall_ack",   64'(req_ack), 64'd0);
            tick();
        end
        avm_waitrequest = 1'b0;
        #1;
        check("stall_final_write", 64'(avm_write), 64'd1);
        check("stall_final_ack",   64'(req_ack), 64'b0100);
        tick();
        req = '0;
        #1;
        check("stall_done_write", 64'(avm_write), 64'd0);

        // Round-robin with all requesters continuously pending, from rr_ptr=0
        apply_reset();
        req = 4'b1111;
        do_grant(0, "rr0");
        do_grant(1, "rr1");
        do_grant(2, "rr2");
        do_grant(3, "rr3");
        do_grant(0, "rr4");
        do_grant(1, "rr5");

        // rr_ptr is now 2: lower requesters reached by wrapping
        req = 4'b0011;
        do_grant(0, "skip0");
        do_grant(1, "skip1");
        req = 4'b1001;
        do_grant(3, "skip3");
        do_grant(0, "skip0b");

        // Data change while stalled must not reach the slave (rr_ptr is 1)
        addr_v[1] = 11'h0AA;
        data_v[1] = 64'h1;
        req = 4'b0010;
        avm_waitrequest = 1'b1;
        tick();
        #1;
        check("iso_gid",  64'(grant_id), 64'd1);
        check("iso_data", avm_writedata, 64'h1);
        tick();
        data_v[1] = 64'h2;
        addr_v[1] = 11'h0BB;
        tick();
        #1;
        check("iso_hold_data", avm_writedata, 64'h1);
        check("iso_hold_addr", 64'(avm_address), 64'h0AA);
        avm_waitrequest = 1'b0;
        #1;
        check("iso_ack",        64'(req_ack), 64'b0010);
        check("iso_final_data", avm_writedata, 64'h1);
        tick();
        req = '0;
        #1;
        check("iso_done_write", 64'(avm_write), 64'd0);

        // Reset while stalled, rr_ptr is 2 before reset
        req = 4'b1000;
        avm_waitrequest = 1'b1;
        tick();
        #1;
        check("mrst_gid",  64'(grant_id), 64'd3);
        check("mrst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        #1;
        check("mrst_no_ack", 64'(req_ack), 64'd0);
        tick();
        reset = 1'b0;
        req = '0;
        #1;
        check("mrst_write", 64'(avm_write), 64'd0);
        check("mrst_busy0", 64'(busy), 64'd0);
        check("mrst_gid0",  64'(grant_id), 64'd0);
        check("mrst_ack0",  64'(req_ack), 64'd0);
        // rr_ptr back at 0: requester 0 wins over 2 and 3
        req = 4'b1101;
        do_grant(0, "mrst_ptr");
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
